// File: rtl/mont_domain_convert.sv
// ---------------------------------------------------------------------------
// mont_domain_convert
//
// Bit-serial radix-2 Montgomery multiplier used to move operands into and out
// of the Montgomery domain on the RSA decryption path.  It computes
// y = A * B * R^-1 mod N with R = 2^DATA_LENGTH:
//   dir = 0 : B = R^2 mod N  ->  y = x * R mod N     (into the domain)
//   dir = 1 : B = 1          ->  y = x * R^-1 mod N  (out of the domain)
//
// Ports
//   clk     in   1            rising-edge clock
//   rst_n   in   1            asynchronous active-low reset
//   start   in   1            request, sampled only in IDLE (ignored while done)
//   dir     in   1            0 = into domain, 1 = out of domain
//   x_in    in   DATA_LENGTH  operand, any value
//   N_in    in   DATA_LENGTH  modulus, must be odd
//   R_t_in  in   DATA_LENGTH  R^2 mod N, used only when dir = 0
//   busy    out  1            high from the capture edge until done rises
//   done    out  1            one-cycle pulse, y_out/err valid from here
//   err     out  1            modulus was even at capture, y_out forced to 0
//   y_out   out  DATA_LENGTH  fully reduced result, held until the next done
//
// Timing: capture on edge 1, one iteration per edge on edges 2..W+1, done on
// edge W+2.  An even modulus skips the iterations and finishes on edge 2.
// ---------------------------------------------------------------------------
module mont_domain_convert #(
    parameter int DATA_LENGTH = 1024,
    parameter int CNT_W       = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   dir,
    input  logic [DATA_LENGTH-1:0] x_in,
    input  logic [DATA_LENGTH-1:0] N_in,
    input  logic [DATA_LENGTH-1:0] R_t_in,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [DATA_LENGTH-1:0] y_out
);

    localparam int W = DATA_LENGTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    state_t           r_state;
    logic [W+1:0]     r_s;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_n;
    logic [CNT_W-1:0] r_cnt;
    logic             r_errPend;

    logic [W+1:0]     w_sumAdd;
    logic [W+1:0]     w_sumRed;
    logic [W+1:0]     w_sNext;
    logic             w_geN;
    logic [W-1:0]     w_sMinusN;
    logic [W-1:0]     w_result;

    // One Montgomery step.  Adding N when the partial sum is odd makes it
    // even, so the shift right is an exact division by two modulo N.  With
    // S < 2N and B < N the sum stays below 4N, which fits in W+2 bits.
    assign w_sumAdd = r_s + (r_a[0] ? {2'b00, r_b} : '0);
    assign w_sumRed = w_sumAdd[0] ? (w_sumAdd + {2'b00, r_n}) : w_sumAdd;
    assign w_sNext  = w_sumRed >> 1;

    // Final conditional subtraction.  When S >= N we know S - N < N < 2^W,
    // so doing the subtraction on the low W bits gives the exact answer.
    assign w_geN     = (r_s >= {2'b00, r_n});
    assign w_sMinusN = r_s[W-1:0] - r_n;
    assign w_result  = w_geN ? w_sMinusN : r_s[W-1:0];

    // Control and datapath registers.  All outputs are registered here so
    // busy/done/err/y_out change only on clock edges (or on reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_s       <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_n       <= '0;
            r_cnt     <= '0;
            r_errPend <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            y_out     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    // A request in the same cycle as done is dropped, which
                    // gives a held start exactly one idle cycle between jobs.
                    if (start && !done) begin
                        r_a       <= x_in;
                        r_n       <= N_in;
                        r_b       <= dir ? W'(1) : R_t_in;
                        r_s       <= '0;
                        r_cnt     <= CNT_W'(W);
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        r_errPend <= ~N_in[0];
                        r_state   <= N_in[0] ? ST_MUL : ST_FINAL;
                    end
                end

                ST_MUL: begin
                    r_s   <= w_sNext;
                    r_a   <= r_a >> 1;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Leave on the edge where the counter reaches zero.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_FINAL;
                    end
                end

                ST_FINAL: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    r_errPend <= 1'b0;
                    if (r_errPend) begin
                        y_out <= '0;
                        err   <= 1'b1;
                    end else begin
                        y_out <= w_result;
                        err   <= 1'b0;
                    end
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_domain_convert.sv
// ---------------------------------------------------------------------------
// tb_mont_domain_convert
//
// Self-checking bench for mont_domain_convert.  Two instances are built, one
// with W = 8 and one with W = 64, sharing clock and reset.  Expected results
// come from plain modular arithmetic: x*R mod N for the forward direction and
// repeated modular halving (multiplication by 2^-1) for the reverse one.
// ---------------------------------------------------------------------------
module tb_mont_domain_convert;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic        start8, dir8, busy8, done8, err8;
    logic [7:0]  x8, n8, rt8, y8;
    logic        start64, dir64, busy64, done64, err64;
    logic [63:0] x64, n64, rt64, y64;

    int nCompared   = 0;
    int nMismatched = 0;

    mont_domain_convert #(.DATA_LENGTH(8), .CNT_W(4)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .dir    (dir8),
        .x_in   (x8),
        .N_in   (n8),
        .R_t_in (rt8),
        .busy   (busy8),
        .done   (done8),
        .err    (err8),
        .y_out  (y8)
    );

    mont_domain_convert #(.DATA_LENGTH(64), .CNT_W(7)) dut64 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start64),
        .dir    (dir64),
        .x_in   (x64),
        .N_in   (n64),
        .R_t_in (rt64),
        .busy   (busy64),
        .done   (done64),
        .err    (err64),
        .y_out  (y64)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // 2^w mod n by repeated doubling.
    function automatic logic [127:0] pow2Mod(input int w, input logic [127:0] n);
        logic [127:0] r;
        r = 128'd1 % n;
        for (int i = 0; i < w; i++) r = (r * 128'd2) % n;
        return r;
    endfunction

    function automatic logic [63:0] rtFor(input int w, input logic [127:0] n);
        logic [127:0] r;
        r = pow2Mod(w, n);
        return 64'((r * r) % n);
    endfunction

    function automatic logic [63:0] modelTo(input int w, input logic [127:0] x,
                                            input logic [127:0] n);
        return 64'(((x % n) * pow2Mod(w, n)) % n);
    endfunction

    // x * 2^-w mod n: halving an odd residue means adding n first.
    function automatic logic [63:0] modelFrom(input int w, input logic [127:0] x,
                                              input logic [127:0] n);
        logic [127:0] v;
        v = x % n;
        for (int i = 0; i < w; i++) v = v[0] ? ((v + n) >> 1) : (v >> 1);
        return 64'(v);
    endfunction

    task automatic applyStimulus(input bit big, input logic s, input logic d,
                                 input logic [63:0] x, input logic [63:0] n,
                                 input logic [63:0] rt);
        if (big) begin
            start64 = s; dir64 = d; x64 = x; n64 = n; rt64 = rt;
        end else begin
            start8 = s; dir8 = d; x8 = x[7:0]; n8 = n[7:0]; rt8 = rt[7:0];
        end
    endtask

    // Runs one conversion; optionally re-pulses start before edge
    // interfereEdge (capture = edge 1).  Checks latency and busy profile.
    task automatic runJob(input bit big, input logic d, input logic [63:0] x,
                          input logic [63:0] n, input logic [63:0] rt,
                          input int interfereEdge, output logic [63:0] y,
                          output logic e, output logic errAtCap);
        int w;
        int cycles;
        bit gotDone;
        bit busyOk;
        logic bsy;
        w = big ? 64 : 8;
        @(posedge clk);
        @(negedge clk);
        applyStimulus(big, 1'b1, d, x, n, rt);
        @(posedge clk);
        #1;
        errAtCap = big ? err64 : err8;
        busyOk   = big ? busy64 : busy8;
        applyStimulus(big, 1'b0, 1'($urandom), {$urandom, $urandom},
                      {$urandom, $urandom}, {$urandom, $urandom});
        cycles  = 0;
        gotDone = 0;
        while (!gotDone && cycles < 300) begin
            if (interfereEdge == cycles + 2) begin
                @(negedge clk);
                applyStimulus(big, 1'b1, ~d, {$urandom, $urandom}, n, rt);
                @(posedge clk);
                #1;
                applyStimulus(big, 1'b0, d, x, n, rt);
            end else begin
                @(posedge clk);
                #1;
            end
            cycles++;
            gotDone = big ? done64 : done8;
            bsy     = big ? busy64 : busy8;
            if (gotDone == bsy) busyOk = 0;
        end
        checkOutput($sformatf("latencyW%0d", w), 64'(cycles), n[0] ? 64'(w + 1) : 64'd1);
        checkOutput($sformatf("busyProfileW%0d", w), {63'd0, busyOk}, 64'd1);
        y = big ? y64 : {56'd0, y8};
        e = big ? err64 : err8;
    endtask

    initial begin
        logic [63:0] y, y2, x, n, rt;
        logic        e, ec;
        int          edgeNo;
        int          doneEdges[$];

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
        #12;
        checkOutput("rstBusy", {63'd0, busy8}, 64'd0);
        checkOutput("rstDone", {63'd0, done8}, 64'd0);
        checkOutput("rstErr", {63'd0, err8}, 64'd0);
        checkOutput("rstY", {56'd0, y8}, 64'd0);
        checkOutput("rstY64", y64, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed W = 8 cases, N = 239, R^2 mod N = 50.
        runJob(1'b0, 1'b0, 64'd5, 64'd239, 64'd50, 0, y, e, ec);
        checkOutput("to5", y, 64'd85);
        checkOutput("to5Err", {63'd0, e}, 64'd0);
        @(posedge clk);
        #1;
        checkOutput("donePulse", {63'd0, done8}, 64'd0);
        checkOutput("yHeld", {56'd0, y8}, 64'd85);

        runJob(1'b0, 1'b1, 64'd85, 64'd239, 64'd50, 0, y, e, ec);
        checkOutput("from85", y, 64'd5);
        runJob(1'b0, 1'b1, 64'd1, 64'd239, 64'd50, 0, y, e, ec);
        checkOutput("from1", y, 64'd225);
        runJob(1'b0, 1'b0, 64'd255, 64'd239, 64'd50, 0, y, e, ec);
        checkOutput("to255", y, 64'd33);
        runJob(1'b0, 1'b0, 64'd0, 64'd239, 64'd50, 0, y, e, ec);
        checkOutput("to0", y, 64'd0);
        runJob(1'b0, 1'b1, 64'd0, 64'd239, 64'd50, 0, y, e, ec);
        checkOutput("from0", y, 64'd0);
        runJob(1'b0, 1'b0, 64'd77, 64'd1, 64'd0, 0, y, e, ec);
        checkOutput("nIsOne", y, 64'd0);

        // Even modulus, then a valid job clears err at capture.
        runJob(1'b0, 1'b0, 64'd5, 64'd238, 64'd50, 0, y, e, ec);
        checkOutput("evenY", y, 64'd0);
        checkOutput("evenErr", {63'd0, e}, 64'd1);
        runJob(1'b0, 1'b1, 64'd85, 64'd239, 64'd50, 0, y, e, ec);
        checkOutput("errClrAtCap", {63'd0, ec}, 64'd0);
        checkOutput("errClrDone", {63'd0, e}, 64'd0);
        checkOutput("afterErrY", y, 64'd5);

        // start pulsed at edge 4 of a running job must be ignored.
        runJob(1'b0, 1'b0, 64'd5, 64'd239, 64'd50, 4, y, e, ec);
        checkOutput("interfereY", y, 64'd85);

        // start held high: back-to-back jobs W+3 = 11 cycles apart.
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 64'd5, 64'd239, 64'd50);
        edgeNo = 0;
        while (doneEdges.size() < 2 && edgeNo < 60) begin
            @(posedge clk);
            #1;
            edgeNo++;
            if (done8) begin
                doneEdges.push_back(edgeNo);
                checkOutput("b2bY", {56'd0, y8}, 64'd85);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd5, 64'd239, 64'd50);
        checkOutput("b2bCount", 64'(doneEdges.size()), 64'd2);
        if (doneEdges.size() == 2) begin
            checkOutput("b2bFirst", 64'(doneEdges[0]), 64'd10);
            checkOutput("b2bGap", 64'(doneEdges[1] - doneEdges[0]), 64'd11);
        end

        // Reset dropped after edge 5 of a job: outputs clear without a clock.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 64'd7, 64'd239, 64'd50);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd7, 64'd239, 64'd50);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstBusy", {63'd0, busy8}, 64'd0);
        checkOutput("midRstDone", {63'd0, done8}, 64'd0);
        checkOutput("midRstY", {56'd0, y8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runJob(1'b0, 1'b0, 64'd200, 64'd239, 64'd50, 0, y, e, ec);
        checkOutput("postRstY", y, modelTo(8, 128'd200, 128'd239));

        // Randomized W = 8 with round trips.
        for (int i = 0; i < 20; i++) begin
            n  = 64'($urandom_range(0, 255)) | 64'd1;
            x  = 64'($urandom_range(0, 255));
            rt = rtFor(8, {64'd0, n});
            runJob(1'b0, 1'b0, x, n, rt, 0, y, e, ec);
            checkOutput($sformatf("rnd8To[%0d]", i), y, modelTo(8, {64'd0, x}, {64'd0, n}));
            runJob(1'b0, 1'b1, y, n, 64'($urandom), 0, y2, e, ec);
            checkOutput($sformatf("rnd8Trip[%0d]", i), y2, x % n);
            x = 64'($urandom_range(0, 255));
            runJob(1'b0, 1'b1, x, n, rt, 0, y, e, ec);
            checkOutput($sformatf("rnd8From[%0d]", i), y, modelFrom(8, {64'd0, x}, {64'd0, n}));
        end

        // Randomized W = 64 with round trips.
        for (int i = 0; i < 6; i++) begin
            n = {$urandom, $urandom} | 64'd1;
            if (i % 2 == 0) n[63] = 1'b1;
            x  = {$urandom, $urandom};
            rt = rtFor(64, {64'd0, n});
            runJob(1'b1, 1'b0, x, n, rt, 0, y, e, ec);
            checkOutput($sformatf("rnd64To[%0d]", i), y, modelTo(64, {64'd0, x}, {64'd0, n}));
            runJob(1'b1, 1'b1, y, n, {$urandom, $urandom}, 0, y2, e, ec);
            checkOutput($sformatf("rnd64Trip[%0d]", i), y2, x % n);
            x = {$urandom, $urandom};
            runJob(1'b1, 1'b1, x, n, rt, 0, y, e, ec);
            checkOutput($sformatf("rnd64From[%0d]", i), y, modelFrom(64, {64'd0, x}, {64'd0, n}));
        end

        runJob(1'b1, 1'b0, 64'd9, 64'd1000, 64'd3, 0, y, e, ec);
        checkOutput("even64Y", y, 64'd0);
        checkOutput("even64Err", {63'd0, e}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
